mmio_gpio: RTL

Parametrised memory-mapped GPIO unit between the multi-cycle RISC-V core's data bus and the board pins (LEDs out, switch/button lines in). Replaces the direct mapping of a raw IO word onto the LEDs with addressable registers, a request/ready bus handshake, synchronised inputs, and optional per-channel PWM dimming driven by an internal prescaler. One instance per IO bank; width, channel count and prescaler are set per instance.

---
 rtl/mmio_pkg.sv | 18 +
 rtl/pwm_tick_gen.sv | 42 ++++
 rtl/mmio_gpio.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Register map and bus FSM encoding shared by the mmio_gpio bank.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package mmio_pkg;

    localparam int ADDR_OUT       = 0;
    localparam int ADDR_IN        = 1;
    localparam int ADDR_DIV       = 2;
    localparam int ADDR_DUTY_BASE = 4;

    localparam logic [7:0] DUTY_FULL = 8'hFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } bus_state_t;

endpackage

// File: rtl/pwm_tick_gen.sv
// PWM timebase: prescaler counting DIV down to 0 (one-cycle tick at 0) plus an 8-bit phase counter.
// Latency: div_load reloads the prescaler on the same edge; phase advances on the edge that ends a tick cycle.
// Backpressure: none, free-running.
module pwm_tick_gen #(
    parameter int DIV_WIDTH = 16,
    parameter int DIV_RESET = 195
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_WIDTH-1:0] div_cfg,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_load_dat,
    output logic                 tick,
    output logic [7:0]           phase
);

    logic [DIV_WIDTH-1:0] cnt_q;

    assign tick = (cnt_q == '0);

    // A register write restarts the count from the new value; phase keeps running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= DIV_WIDTH'(DIV_RESET);
        end else if (div_load) begin
            cnt_q <= div_load_dat;
        end else if (tick) begin
            cnt_q <= div_cfg;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 8'd0;
        end else if (tick) begin
            phase <= phase + 8'd1;
        end
    end

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO bank: OUT/IN registers, 2-flop input sync, PWM dimming when MMIO_GPIO_PWM_EN is defined.
// Latency: bus_ready one cycle after the accepting edge; OUT write reaches gpio_out one edge later.
// Backpressure: at most one access per two cycles; bus_valid is ignored while the response is presented.
module mmio_gpio
    import mmio_pkg::*;
#(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int CHANNELS   = 8,
    parameter int IN_WIDTH   = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int DIV_RESET  = 195
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bus_valid,
    input  logic                  bus_we,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [BUS_WIDTH-1:0]  bus_wdata,
    output logic                  bus_ready,
    output logic [BUS_WIDTH-1:0]  bus_rdata,
    input  logic [IN_WIDTH-1:0]   gpio_in,
    output logic [CHANNELS-1:0]   gpio_out
);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BUS_WIDTH-1:0]  dat;
    } bus_req_t;

    bus_state_t            state_q, state_nxt;
    bus_req_t              req;
    logic                  req_vld;
    logic                  wr_vld;
    logic [BUS_WIDTH-1:0]  rd_dat;
    logic [BUS_WIDTH-1:0]  rdata_q;
    logic [CHANNELS-1:0]   out_q;
    logic [IN_WIDTH-1:0]   sync_meta, sync_q;
    logic                  unused_ok;

    assign req     = '{we: bus_we, addr: bus_addr, dat: bus_wdata};
    assign req_vld = (state_q == ST_IDLE) && bus_valid;
    assign wr_vld  = req_vld && req.we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (bus_valid) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus_ready = (state_q == ST_RESP);
    assign bus_rdata = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= gpio_in;
            sync_q    <= sync_meta;
        end
    end

`ifdef MMIO_GPIO_PWM_EN
    logic [DIV_WIDTH-1:0] div_q;
    logic [7:0]           duty_q [CHANNELS];
    logic                 pwm_tick;
    logic [7:0]           pwm_phase;
    logic [CHANNELS-1:0]  pwm_on;
    logic                 div_wr;

    assign div_wr = wr_vld && (req.addr == ADDR_WIDTH'(ADDR_DIV));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= DIV_WIDTH'(DIV_RESET);
            for (int ch = 0; ch < CHANNELS; ch++) duty_q[ch] <= DUTY_FULL;
        end else if (wr_vld) begin
            if (div_wr) div_q <= req.dat[DIV_WIDTH-1:0];
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (req.addr == ADDR_WIDTH'(ADDR_DUTY_BASE + ch)) duty_q[ch] <= req.dat[7:0];
            end
        end
    end

    pwm_tick_gen #(
        .DIV_WIDTH (DIV_WIDTH),
        .DIV_RESET (DIV_RESET)
    ) u_tick (
        .clk          (clk),
        .rst_n        (rst_n),
        .div_cfg      (div_q),
        .div_load     (div_wr),
        .div_load_dat (req.dat[DIV_WIDTH-1:0]),
        .tick         (pwm_tick),
        .phase        (pwm_phase)
    );

    // Full-scale duty must stay lit through phase 255, which a plain compare would miss.
    always_comb begin
        pwm_on = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            pwm_on[ch] = (duty_q[ch] == DUTY_FULL) || (pwm_phase < duty_q[ch]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gpio_out <= '0;
        else        gpio_out <= out_q & pwm_on;
    end

    assign unused_ok = ^{req.dat, pwm_tick};
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gpio_out <= '0;
        else        gpio_out <= out_q;
    end

    assign unused_ok = ^req.dat;
`endif

    always_comb begin
        rd_dat = '0;
        if (req.addr == ADDR_WIDTH'(ADDR_OUT)) rd_dat[CHANNELS-1:0] = out_q;
        if (req.addr == ADDR_WIDTH'(ADDR_IN))  rd_dat[IN_WIDTH-1:0] = sync_q;
`ifdef MMIO_GPIO_PWM_EN
        if (req.addr == ADDR_WIDTH'(ADDR_DIV)) rd_dat[DIV_WIDTH-1:0] = div_q;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (req.addr == ADDR_WIDTH'(ADDR_DUTY_BASE + ch)) rd_dat[7:0] = duty_q[ch];
        end
`endif
    end

    // Read data is captured from pre-edge register values, so a same-edge write never leaks in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            out_q   <= '0;
        end else if (req_vld) begin
            rdata_q <= req.we ? '0 : rd_dat;
            if (wr_vld && (req.addr == ADDR_WIDTH'(ADDR_OUT))) out_q <= req.dat[CHANNELS-1:0];
        end
    end

endmodule
